// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: IDLE/BUSY handshake to a data memory, load extension and store lane steering.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_wdata,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic [2:0]  funct3_q, funct3_nx;
    logic [1:0]  lane_q, lane_nx;

    logic        req_nx, we_nx, wb_valid_nx, wb_rw_nx, mis_nx;
    logic [31:0] addr_nx, wdata_nx, wb_data_nx;
    logic [3:0]  be_nx;
    logic [4:0]  wb_rd_nx;

    logic        is_mem, f3_ok, align_ok;
    logic [3:0]  be_calc;
    logic [31:0] store_rep, shifted, load_ext;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_nx;
    logic        berr_nx;
`endif

    assign ex_ready = (state == IDLE);
    assign is_mem   = ex_mem_read | ex_mem_write;

    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b0;
        be_calc  = 4'b0000;
        store_rep = ex_wdata;
        if (ex_mem_read)
            f3_ok = (ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            f3_ok = (ex_funct3 inside {3'b000, 3'b001, 3'b010});
        case (ex_funct3[1:0])
            2'b00: begin
                align_ok  = 1'b1;
                be_calc   = 4'b0001 << ex_alu_result[1:0];
                store_rep = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                align_ok  = ~ex_alu_result[0];
                be_calc   = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{ex_wdata[15:0]}};
            end
            2'b10: begin
                align_ok  = (ex_alu_result[1:0] == 2'b00);
                be_calc   = 4'b1111;
            end
            default: align_ok = 1'b0;
        endcase
    end

    // Read word is shifted so the addressed byte/half lands in the low lanes before extension.
    always_comb begin
        shifted  = dmem_rdata >> {lane_q, 3'b000};
        load_ext = '0;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = dmem_rdata;
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_nx    = state;
        funct3_nx   = funct3_q;
        lane_nx     = lane_q;
        req_nx      = dmem_req;
        we_nx       = dmem_we;
        addr_nx     = dmem_addr;
        be_nx       = dmem_be;
        wdata_nx    = dmem_wdata;
        wb_valid_nx = 1'b0;
        wb_rd_nx    = wb_rd;
        wb_rw_nx    = wb_reg_write;
        wb_data_nx  = wb_data;
        mis_nx      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_nx      = cnt_q;
        berr_nx     = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_TIMEOUT_EN
                cnt_nx = '0;
`endif
                if (ex_valid) begin
                    wb_rd_nx = ex_rd;
                    if (!is_mem) begin
                        wb_valid_nx = 1'b1;
                        wb_rw_nx    = ex_reg_write;
                        wb_data_nx  = ex_alu_result;
                    end else if (!(f3_ok && align_ok)) begin
                        wb_valid_nx = 1'b1;
                        wb_rw_nx    = 1'b0;
                        wb_data_nx  = '0;
                        mis_nx      = 1'b1;
                    end else begin
                        state_nx  = BUSY;
                        req_nx    = 1'b1;
                        we_nx     = ~ex_mem_read;
                        addr_nx   = {ex_alu_result[31:2], 2'b00};
                        be_nx     = be_calc;
                        wdata_nx  = store_rep;
                        funct3_nx = ex_funct3;
                        lane_nx   = ex_alu_result[1:0];
                        wb_rw_nx  = ex_mem_read & ex_reg_write;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_nx    = IDLE;
                    req_nx      = 1'b0;
                    wb_valid_nx = 1'b1;
                    wb_data_nx  = dmem_we ? '0 : load_ext;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    state_nx    = IDLE;
                    req_nx      = 1'b0;
                    wb_valid_nx = 1'b1;
                    wb_rw_nx    = 1'b0;
                    wb_data_nx  = '0;
                    berr_nx     = 1'b1;
                end else begin
                    cnt_nx = cnt_q + 1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            funct3_q     <= '0;
            lane_q       <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            funct3_q     <= funct3_nx;
            lane_q       <= lane_nx;
            dmem_req     <= req_nx;
            dmem_we      <= we_nx;
            dmem_addr    <= addr_nx;
            dmem_be      <= be_nx;
            dmem_wdata   <= wdata_nx;
            wb_valid     <= wb_valid_nx;
            wb_rd        <= wb_rd_nx;
            wb_reg_write <= wb_rw_nx;
            wb_data      <= wb_data_nx;
            misalign_err <= mis_nx;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bus_err <= 1'b0;
        end else begin
            cnt_q   <= cnt_nx;
            bus_err <= berr_nx;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build; timeout case when MEM_TIMEOUT_EN is defined).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_wdata = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_wdata(ex_wdata),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; presents one op for one rising edge, returns on the next falling edge.
    task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        ex_valid = 1'b1; ex_alu_result = alu; ex_wdata = wd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    task automatic ack_cycle(input logic [31:0] rdata);
        dmem_ack = 1'b1; dmem_rdata = rdata;
        @(posedge clk); @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_req",      {31'd0, dmem_req}, 32'd0);
        check("rst_addr",     dmem_addr, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data",  wb_data, 32'd0);
        check("rst_mis",      {31'd0, misalign_err}, 32'd0);
        check("rst_berr",     {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("ready_after_rst", {31'd0, ex_ready}, 32'd1);

        // ALU op
        issue(32'h0000_1234, '0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("alu_wb_data",  wb_data, 32'h0000_1234);
        check("alu_wb_rd",    {27'd0, wb_rd}, 32'd5);
        check("alu_wb_rw",    {31'd0, wb_reg_write}, 32'd1);
        check("alu_no_req",   {31'd0, dmem_req}, 32'd0);
        idle_cycle();
        check("alu_pulse_end", {31'd0, wb_valid}, 32'd0);

        // Back-to-back ALU ops
        ex_valid = 1'b1; ex_alu_result = 32'h1111_0001; ex_rd = 5'd1; ex_reg_write = 1'b1;
        @(posedge clk); @(negedge clk);
        check("b2b_first", wb_data, 32'h1111_0001);
        ex_alu_result = 32'h2222_0002; ex_rd = 5'd2;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0;
        check("b2b_second_valid", {31'd0, wb_valid}, 32'd1);
        check("b2b_second", wb_data, 32'h2222_0002);
        check("b2b_second_rd", {27'd0, wb_rd}, 32'd2);

        // LB 0x103, ack after 3 busy cycles
        issue(32'h0000_0103, '0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
        check("lb_req",   {31'd0, dmem_req}, 32'd1);
        check("lb_addr",  dmem_addr, 32'h0000_0100);
        check("lb_we",    {31'd0, dmem_we}, 32'd0);
        check("lb_busy",  {31'd0, ex_ready}, 32'd0);
        idle_cycle();
        idle_cycle();
        check("lb_req_held", {31'd0, dmem_req}, 32'd1);
        check("lb_addr_held", dmem_addr, 32'h0000_0100);
        check("lb_no_wb", {31'd0, wb_valid}, 32'd0);
        ack_cycle(32'h80FF_0000);
        check("lb_req_drop", {31'd0, dmem_req}, 32'd0);
        check("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("lb_data",     wb_data, 32'hFFFF_FF80);
        check("lb_rd",       {27'd0, wb_rd}, 32'd7);
        check("lb_rw",       {31'd0, wb_reg_write}, 32'd1);
        check("lb_ready",    {31'd0, ex_ready}, 32'd1);

        // LBU same address
        issue(32'h0000_0103, '0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b100);
        ack_cycle(32'h80FF_0000);
        check("lbu_data", wb_data, 32'h0000_0080);

        // LH / LHU on upper half
        issue(32'h0000_0102, '0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001);
        check("lh_be", {28'd0, dmem_be}, 32'h0000_000C);
        ack_cycle(32'h8001_7FFF);
        check("lh_data", wb_data, 32'hFFFF_8001);
        issue(32'h0000_0102, '0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b101);
        ack_cycle(32'h8001_7FFF);
        check("lhu_data", wb_data, 32'h0000_8001);

        // LW
        issue(32'h0000_0104, '0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010);
        check("lw_addr", dmem_addr, 32'h0000_0104);
        ack_cycle(32'hDEAD_BEEF);
        check("lw_data", wb_data, 32'hDEAD_BEEF);

        // SH 0x202
        issue(32'h0000_0202, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
        check("sh_req",   {31'd0, dmem_req}, 32'd1);
        check("sh_we",    {31'd0, dmem_we}, 32'd1);
        check("sh_addr",  dmem_addr, 32'h0000_0200);
        check("sh_be",    {28'd0, dmem_be}, 32'h0000_000C);
        check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        ack_cycle(32'h0);
        check("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("sh_rw",       {31'd0, wb_reg_write}, 32'd0);

        // SB 0x201 and SW 0x300
        issue(32'h0000_0201, 32'h1234_565A, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
        check("sb_be",    {28'd0, dmem_be}, 32'h0000_0002);
        check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        ack_cycle(32'h0);
        issue(32'h0000_0300, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        check("sw_be",    {28'd0, dmem_be}, 32'h0000_000F);
        check("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        ack_cycle(32'h0);

        // Read and write both set: load wins
        issue(32'h0000_0300, 32'h5555_5555, 5'd11, 1'b1, 1'b1, 1'b1, 3'b010);
        check("rw_prio_we", {31'd0, dmem_we}, 32'd0);
        ack_cycle(32'h0BAD_CAFE);
        check("rw_prio_data", wb_data, 32'h0BAD_CAFE);

        // Misaligned LW 0x101
        issue(32'h0000_0101, '0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010);
        check("mis_no_req",   {31'd0, dmem_req}, 32'd0);
        check("mis_err",      {31'd0, misalign_err}, 32'd1);
        check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("mis_rw",       {31'd0, wb_reg_write}, 32'd0);
        check("mis_ready",    {31'd0, ex_ready}, 32'd1);
        idle_cycle();
        check("mis_pulse_end", {31'd0, misalign_err}, 32'd0);

        // Undefined funct3 on aligned load
        issue(32'h0000_0100, '0, 5'd13, 1'b1, 1'b1, 1'b0, 3'b011);
        check("undef_err",    {31'd0, misalign_err}, 32'd1);
        check("undef_no_req", {31'd0, dmem_req}, 32'd0);

        // Ack while idle is ignored
        ack_cycle(32'hFFFF_FFFF);
        check("idle_ack_wb",  {31'd0, wb_valid}, 32'd0);
        check("idle_ack_req", {31'd0, dmem_req}, 32'd0);

        // Reset during BUSY abandons the access
        issue(32'h0000_0400, '0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b010);
        check("rstbusy_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstbusy_req_async",  {31'd0, dmem_req}, 32'd0);
        check("rstbusy_addr_async", dmem_addr, 32'd0);
        check("rstbusy_wb_rd",      {27'd0, wb_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rstbusy_ready", {31'd0, ex_ready}, 32'd1);
        ack_cycle(32'h1234_5678);
        check("rstbusy_no_wb", {31'd0, wb_valid}, 32'd0);
        check("berr_zero",     {31'd0, bus_err}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        issue(32'h0000_0500, '0, 5'd15, 1'b1, 1'b1, 1'b0, 3'b010);
        for (int i = 0; i < 15; i++) idle_cycle();
        check("to_still_busy", {31'd0, dmem_req}, 32'd1);
        check("to_no_berr",    {31'd0, bus_err}, 32'd0);
        idle_cycle();
        check("to_berr",     {31'd0, bus_err}, 32'd1);
        check("to_req_drop", {31'd0, dmem_req}, 32'd0);
        check("to_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("to_rw",       {31'd0, wb_reg_write}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, ack watchdog limit (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ex_valid  in  1  EX-stage op present.
REQ-005 SHALL have port ex_ready  out  1  stage can accept an op this cycle.
REQ-006 SHALL have port ex_alu_result  in  32  ALU result; effective address for loads/stores.
REQ-007 SHALL have port ex_wdata  in  32  store data (rs2).
REQ-008 SHALL have port ex_mem_read  in  1  op is a load.
REQ-009 SHALL have port ex_mem_write  in  1  op is a store.
REQ-010 SHALL have port ex_funct3  in  3  access size/sign.
REQ-011 SHALL have port ex_rd  in  5  destination register.
REQ-012 SHALL have port ex_reg_write  in  1  op writes rd.
REQ-013 SHALL have port dmem_req  out  1  data-memory request, held until ack.
REQ-014 SHALL have port dmem_we  out  1  1 = write.
REQ-015 SHALL have port dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-016 SHALL have port dmem_be  out  4  byte enables.
REQ-017 SHALL have port dmem_wdata  out  32  lane-replicated store data.
REQ-018 SHALL have port dmem_ack  in  1  request complete; rdata valid this cycle for reads.
REQ-019 SHALL have port dmem_rdata  in  32  read word.
REQ-020 SHALL have port wb_valid  out  1  one-cycle pulse, result for WB.
REQ-021 SHALL have ports wb_rd (out 5), wb_reg_write (out 1), wb_data (out 32): WB destination, enable, value.
REQ-022 SHALL have ports misalign_err (out 1) and bus_err (out 1): one-cycle error pulses.

Function
REQ-023 SHALL implement FSM IDLE/BUSY; ex_ready = (state==IDLE); op accepted when ex_valid && ex_ready.
REQ-024 Non-memory op: wb_valid=1 next cycle, wb_data=ex_alu_result, wb_rd/wb_reg_write captured; state stays IDLE (1-cycle latency, back-to-back ops allowed).
REQ-025 Memory op, aligned: IDLE->BUSY; dmem_req asserted from the cycle after acceptance; dmem_addr/we/be/wdata stable while dmem_req=1.
REQ-026 In BUSY, dmem_ack=1: dmem_req drops next cycle, wb_valid pulses next cycle, -> IDLE; minimum load/store latency 2 cycles.
REQ-027 Alignment: halfword requires addr[0]=0, word requires addr[1:0]=0; misaligned op issues no request, pulses misalign_err and wb_valid with wb_reg_write=0 next cycle.
REQ-028 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half selected by addr[1:0], sign- or zero-extended to 32 bits.
REQ-029 Stores: funct3 000 SB (be = 1<<addr[1:0], byte replicated x4), 001 SH (be 0011/1100, half replicated x2), 010 SW (be 1111); wb_reg_write=0 for stores.
REQ-030 Undefined funct3 on a memory op SHALL be treated as misaligned (REQ-027 behaviour).
REQ-031 ex_mem_read and ex_mem_write both 1: load takes priority.
REQ-032 dmem_ack while IDLE SHALL be ignored.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and zero every output (dmem_* , wb_*, error pulses); ex_ready=1 after release.
REQ-034 Reset during BUSY SHALL abandon the outstanding access with no wb_valid.

Configuration
REQ-035 With MEM_TIMEOUT_EN defined: counter runs in BUSY; after TIMEOUT_CYCLES cycles without ack, drop dmem_req, pulse bus_err and wb_valid (wb_reg_write=0), -> IDLE. Without it: BUSY waits indefinitely, bus_err tied 0.

Verification
REQ-036 ALU op, ex_alu_result=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd=5.
REQ-037 LB addr 0x103, dmem_rdata=0x80FF_0000, ack after 3 cycles -> dmem_addr=0x100, wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 SH addr 0x202, data 0xABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_reg_write=0.
REQ-039 LW addr 0x101 -> no dmem_req, misalign_err=1 one cycle, wb_reg_write=0.
REQ-040 rst asserted mid-BUSY -> outputs 0 asynchronously, no wb_valid; with MEM_TIMEOUT_EN and no ack -> bus_err after 16 cycles.
